// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM encoding, iteration-counter width and divide-by-zero constant.
package divider_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Unsigned magnitude of a two's-complement value; -128 maps to 8'h80.
  function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/divider_if.sv
// Request/result bundle between ALU control and the divider.
// The master issues START with operands; the slave returns results and status.
interface divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div0
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div0
  );
endinterface

// File: rtl/divider_div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
// Produces the next partial remainder and the quotient bit for this step.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The extra top bit acts as the borrow: a set MSB means the trial went negative.
  always_comb begin
    shifted  = {rem, in_bit};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divider.sv
// Sequential signed divider: IDLE captures magnitudes, CALC runs WIDTH restoring
// iterations, SIGN applies operand signs and registers the results with DONE.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  divider_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] raw_q, raw_d;      // dividend as captured, for the zero-divisor case
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_out_q, quot_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .in_bit   (dvd_q[WIDTH-1]),
    .divisor  (dsr_q),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    raw_d      = raw_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    zero_d     = zero_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    div0_d     = div0_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d      = magnitude(bus.dividend);
          dsr_d      = magnitude(bus.divisor);
          raw_d      = bus.dividend;
          neg_quot_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          neg_rem_d  = bus.dividend[WIDTH-1];
          zero_d     = (bus.divisor == '0);
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = CALC;
        end
      end

      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        if (zero_q) begin
          quot_out_d = DIV0_QUOTIENT;
          rem_out_d  = raw_q;
        end else begin
          quot_out_d = neg_quot_q ? (~dvd_q + 1'b1) : dvd_q;
          rem_out_d  = neg_rem_q  ? (~rem_q + 1'b1) : rem_q;
        end
        div0_d  = zero_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of the others, matching real hardware.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      raw_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      done_q     <= 1'b0;
      div0_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      raw_q      <= raw_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      zero_q     <= zero_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      done_q     <= done_d;
      div0_q     <= div0_d;
    end
  end

  assign bus.quotient  = quot_out_q;
  assign bus.remainder = rem_out_q;
  assign bus.div0      = div0_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_divider.sv
// Directed testbench for the divider: results, fixed latency, START filtering,
// back-to-back issue and asynchronous abort.
module tb_divider;
  import divider_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  divider_if #(.WIDTH(8)) ifc ();

  divider #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Wait for DONE; lat is the number of edges waited, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    vectors++;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ifc.busy && ifc.done) begin
        miscompares++;
        $display("FAIL busy_done_overlap: busy=%b done=%b, required not both high", ifc.busy, ifc.done);
      end
      if (ifc.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_div(input logic [7:0] a, input logic [7:0] b, output int lat);
    ifc.dividend = a;
    ifc.divisor  = b;
    ifc.start    = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ifc.start = 1'b0;
    ifc.dividend = 8'h00;
    ifc.divisor = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({ifc.quotient, ifc.remainder, ifc.busy, ifc.done, ifc.div0} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_state: q=%h r=%h busy=%b done=%b div0=%b, required all zero",
               ifc.quotient, ifc.remainder, ifc.busy, ifc.done, ifc.div0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    do_div(8'd100, 8'd7, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d edges, required 9", lat);
    end
    vectors++;
    if ({ifc.quotient, ifc.remainder, ifc.div0} !== {8'h0E, 8'h02, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_100_7: q=%h r=%h div0=%b, required q=0e r=02 div0=0",
               ifc.quotient, ifc.remainder, ifc.div0);
    end
    @(posedge clk); #1;
    vectors++;
    if (ifc.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse_width: done=%b one cycle later, required 0", ifc.done);
    end
  endtask

  task automatic test_signs();
    int lat;
    do_div(8'hF9, 8'h02, lat);
    vectors++;
    if ({ifc.quotient, ifc.remainder} !== {8'hFD, 8'hFF}) begin
      miscompares++;
      $display("FAIL signs_m7_2: q=%h r=%h, required q=fd r=ff", ifc.quotient, ifc.remainder);
    end
    do_div(8'h07, 8'hFE, lat);
    vectors++;
    if ({ifc.quotient, ifc.remainder} !== {8'hFD, 8'h01}) begin
      miscompares++;
      $display("FAIL signs_7_m2: q=%h r=%h, required q=fd r=01", ifc.quotient, ifc.remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int lat;
    do_div(8'h80, 8'hFF, lat);
    vectors++;
    if ({ifc.quotient, ifc.remainder, ifc.div0} !== {8'h80, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL overflow_m128_m1: q=%h r=%h div0=%b, required q=80 r=00 div0=0",
               ifc.quotient, ifc.remainder, ifc.div0);
    end
    do_div(8'h80, 8'h01, lat);
    vectors++;
    if ({ifc.quotient, ifc.remainder} !== {8'h80, 8'h00}) begin
      miscompares++;
      $display("FAIL overflow_m128_1: q=%h r=%h, required q=80 r=00", ifc.quotient, ifc.remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_div0();
    int lat;
    do_div(8'd25, 8'd0, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL div0_latency: got %0d edges, required 9", lat);
    end
    vectors++;
    if ({ifc.quotient, ifc.remainder, ifc.div0} !== {8'hFF, 8'h19, 1'b1}) begin
      miscompares++;
      $display("FAIL div0_25_0: q=%h r=%h div0=%b, required q=ff r=19 div0=1",
               ifc.quotient, ifc.remainder, ifc.div0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    ifc.dividend = 8'd100;
    ifc.divisor  = 8'd7;
    ifc.start    = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ifc.dividend = 8'd50;
    ifc.divisor  = 8'd5;
    ifc.start    = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    vectors++;
    if ({ifc.busy, ifc.quotient, ifc.remainder, ifc.div0} !== {1'b1, 8'hFF, 8'h19, 1'b1}) begin
      miscompares++;
      $display("FAIL hold_during_calc: busy=%b q=%h r=%h div0=%b, required busy=1 q=ff r=19 div0=1",
               ifc.busy, ifc.quotient, ifc.remainder, ifc.div0);
    end
    wait_done(lat);
    vectors++;
    if (lat !== 5) begin
      miscompares++;
      $display("FAIL ignored_start_latency: got %0d more edges, required 5", lat);
    end
    vectors++;
    if ({ifc.quotient, ifc.remainder, ifc.div0} !== {8'h0E, 8'h02, 1'b0}) begin
      miscompares++;
      $display("FAIL ignored_start_result: q=%h r=%h div0=%b, required q=0e r=02 div0=0",
               ifc.quotient, ifc.remainder, ifc.div0);
    end
    // Issue the next operation during the DONE cycle.
    do_div(8'd50, 8'd5, lat);
    vectors++;
    if (lat !== 9) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d edges, required 9", lat);
    end
    vectors++;
    if ({ifc.quotient, ifc.remainder} !== {8'h0A, 8'h00}) begin
      miscompares++;
      $display("FAIL b2b_50_5: q=%h r=%h, required q=0a r=00", ifc.quotient, ifc.remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int  lat;
    logic saw_done;
    ifc.dividend = 8'd100;
    ifc.divisor  = 8'd7;
    ifc.start    = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({ifc.quotient, ifc.remainder, ifc.busy, ifc.done, ifc.div0} !== 19'h0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: q=%h r=%h busy=%b done=%b div0=%b, required all zero",
               ifc.quotient, ifc.remainder, ifc.busy, ifc.done, ifc.div0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (ifc.done || ifc.busy) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_no_done: activity seen=%b after abort, required 0", saw_done);
    end
    do_div(8'd9, 8'd3, lat);
    vectors++;
    if ({ifc.quotient, ifc.remainder, ifc.div0} !== {8'h03, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL after_reset_9_3: q=%h r=%h div0=%b, required q=03 r=00 div0=0",
               ifc.quotient, ifc.remainder, ifc.div0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_div0();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Sequential signed 8-bit integer divider for the ALU's divide path, the inverse operation of the combinational multiplier. It computes a truncating quotient and remainder with a restoring shift-subtract algorithm, one quotient bit per clock. It sits beside the multiplier in the ALU and reports BUSY so control can stall the pipeline until DONE.

## Interface
- WIDTH, 8, operand and result width in bits; only 8 is verified.
- CLK  input  1  system clock; rising edge.
- RESET  input  1  asynchronous, active-high; clears all state and outputs.
- START  input  1  request a division; sampled only in IDLE.
- DIVIDEND  input  WIDTH  signed two's-complement dividend; sampled with START.
- DIVISOR  input  WIDTH  signed two's-complement divisor; sampled with START.
- QUOTIENT  output  WIDTH  signed quotient, truncated toward zero; registered.
- REMAINDER  output  WIDTH  signed remainder, same sign as the dividend; registered.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when results update.
- DIV0  output  1  registered with the results; high if the divisor was zero.

## Operation
- Reset values: QUOTIENT=0, REMAINDER=0, BUSY=0, DONE=0, DIV0=0, state=IDLE.
- States:
  - IDLE: on START=1, capture |DIVIDEND| and |DIVISOR| as unsigned WIDTH-bit magnitudes, the two sign bits, and a zero-divisor flag. Clear the partial remainder and count, then go to CALC.
  - CALC: each cycle, shift the remainder left, bringing in the dividend MSB. Trial-subtract the divisor at WIDTH+1 bits. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0. After WIDTH iterations, go to SIGN.
  - SIGN: negate the quotient if the operand signs differ, and negate the remainder if the dividend was negative. Register QUOTIENT, REMAINDER and DIV0, pulse DONE, and return to IDLE.
- Magnitude of -128 is 8'h80 as unsigned; it must not saturate.
- Overflow: -128 / -1 gives QUOTIENT=8'h80, REMAINDER=0, DIV0=0 (two's-complement wrap, no flag).
- Divide by zero: the full schedule still runs, giving constant latency. In SIGN the outputs are forced to QUOTIENT=8'hFF, REMAINDER=DIVIDEND as captured, DIV0=1.
- START while BUSY=1 is ignored. Operands are not re-sampled during an operation.
- Outputs hold their last values until the next SIGN cycle; they do not change during CALC.
- RESET asserted mid-operation aborts the operation immediately; no DONE is produced.

## Timing
- Edge E0 (START=1 in IDLE) moves the block to CALC; BUSY=1 from just after E0.
- Edges E1..E8 perform the 8 iterations; E8 moves the block to SIGN.
- Edge E9 registers the results. DONE=1 and BUSY=0 for the cycle after E9; the state is then IDLE.
- Fixed latency is 9 clocks from the accepting edge to valid results, identical for every operand pair, including zero divisor.
- START asserted during the DONE cycle is accepted at the next edge, giving back-to-back operations with one idle-visible cycle.
- BUSY and DONE are never high together.

## Structure
- Shared package holds:
  - DIV_WIDTH = 8;
  - the state encoding typedef: IDLE, CALC, SIGN (2-bit);
  - the iteration count width, $clog2(DIV_WIDTH)+1;
  - the divide-by-zero quotient constant 8'hFF.
- One combinational sub-module, div_step, takes the partial remainder, the incoming dividend bit and the divisor. It returns the next remainder and the quotient bit (WIDTH+1-bit subtract and restore). The FSM, counter, sign logic and output registers stay in divider.

## Test plan
- 100 / 7 -> QUOTIENT=8'h0E, REMAINDER=8'h02, DIV0=0; DONE exactly 9 clocks after the accepting edge.
- -7 / 2 (8'hF9, 8'h02) -> QUOTIENT=8'hFD, REMAINDER=8'hFF; 7 / -2 -> QUOTIENT=8'hFD, REMAINDER=8'h01.
- -128 / -1 -> QUOTIENT=8'h80, REMAINDER=8'h00, DIV0=0; -128 / 1 -> QUOTIENT=8'h80, REMAINDER=8'h00.
- 25 / 0 -> QUOTIENT=8'hFF, REMAINDER=8'h19, DIV0=1, same 9-clock latency.
- Change operands and re-assert START at clock 3 of a 100 / 7 run -> ignored; result 8'h0E/8'h02. Then START in the DONE cycle with 50 / 5 -> accepted; result 8'h0A/8'h00.
- RESET at clock 4 of an operation -> all outputs 0 and no DONE. Then 9 / 3 -> QUOTIENT=8'h03, REMAINDER=8'h00.
